// File: rtl/servo_pkg.sv
// Shared constants for the multi-channel BT servo path: ASCII command bytes,
// parser state encoding and the pulse-width table builder.
package servo_pkg;

   localparam logic [7:0] ASC_A  = 8'h41;
   localparam logic [7:0] ASC_B  = 8'h42;
   localparam logic [7:0] ASC_P  = 8'h50;
   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      GOT_P,
      GOT_CH
   } parse_state_t;

   // Width in us for position p; only ever evaluated with constant arguments.
   function automatic int unsigned pulse_us(input int unsigned p,
                                            input int unsigned n_pos,
                                            input int unsigned min_us,
                                            input int unsigned max_us);
      return min_us + (p * (max_us - min_us)) / (n_pos - 1);
   endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: frame-aligned shadow of the commanded position and the
// pulse comparator against the shared microsecond counter.
module servo_pwm_ch
   import servo_pkg::*;
#(
   parameter int N_POS  = 5,
   parameter int MIN_US = 1000,
   parameter int MAX_US = 2000,
   parameter int UW     = 15,
   parameter int POS_W  = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [UW-1:0]    us_cnt,
   input  logic             frame_start,
   input  logic [POS_W-1:0] pos,
   output logic             pwm
);

   logic [UW-1:0]    width_tab [N_POS];
   logic [POS_W-1:0] shadow;

   for (genvar k = 0; k < N_POS; k++) begin : g_tab
      assign width_tab[k] = UW'(pulse_us(k, N_POS, MIN_US, MAX_US));
   end

   // Shadow only follows pos at frame boundaries so a pulse is never cut or stretched.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         shadow <= '0;
         pwm    <= 1'b0;
      end else begin
         if (frame_start) begin
            shadow <= pos;
         end
         pwm <= (us_cnt < width_tab[shadow]);
      end
   end

endmodule

// File: rtl/bt_servo_multi.sv
// ASCII command parser, PWM timebase and ping-pong sweep driving N_CH servo
// channels from HM-10 UART bytes.
module bt_servo_multi
   import servo_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int N_CH      = 4,
   parameter int N_POS     = 5,
   parameter int PERIOD_US = 20000,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int DWELL_MS  = 500,
   localparam int POS_W    = $clog2(N_POS)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [N_CH-1:0]       pwm,
   output logic                  modo,
   output logic [N_CH*POS_W-1:0] pos_flat,
   output logic                  frame_start,
   output logic                  cmd_ok,
   output logic                  cmd_err
);

   localparam int DIV  = CLK_HZ / 1_000_000;
   localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int UW   = $clog2(PERIOD_US);
   localparam int DWW  = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [DW-1:0]    div_cnt;
   logic [UW-1:0]    us_cnt;
   logic             us_tick;
   logic [9:0]       ms_cnt;
   logic             ms_tick;
   logic [DWW-1:0]   dwell_cnt;
   logic [POS_W-1:0] idx;
   logic [POS_W-1:0] idx_next;
   logic             dir_up;
   logic             dir_next;
   logic [CH_W-1:0]  ch;
   logic [POS_W-1:0] pos [N_CH];
   parse_state_t     state;
   logic             byte_live;
   logic             is_ch_digit;
   logic             is_pos_digit;

   assign us_tick      = (div_cnt == DW'(DIV - 1));
   assign ms_tick      = us_tick && (ms_cnt == 10'd999);
   assign byte_live    = rx_valid && (rx_data != ASC_CR) && (rx_data != ASC_LF);
   assign is_ch_digit  = (rx_data >= ASC_0 + 8'd1) && (rx_data <= ASC_0 + 8'(N_CH));
   assign is_pos_digit = (rx_data >= ASC_0 + 8'd1) && (rx_data <= ASC_0 + 8'(N_POS));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt     <= '0;
         us_cnt      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (us_tick) begin
            div_cnt <= '0;
            if (us_cnt == UW'(PERIOD_US - 1)) begin
               us_cnt      <= '0;
               frame_start <= 1'b1;
            end else begin
               us_cnt <= us_cnt + 1'b1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Ping-pong step: turn around at either end without repeating the endpoint.
   always_comb begin
      idx_next = idx;
      dir_next = dir_up;
      if (dir_up) begin
         if (idx == POS_W'(N_POS - 1)) begin
            idx_next = idx - 1'b1;
            dir_next = 1'b0;
         end else begin
            idx_next = idx + 1'b1;
         end
      end else begin
         if (idx == '0) begin
            idx_next = POS_W'(1);
            dir_next = 1'b1;
         end else begin
            idx_next = idx - 1'b1;
         end
      end
   end

   // Parser assignments come after the sweep so a restarting 'B' overrides a coincident step.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         ch        <= '0;
         modo      <= 1'b0;
         cmd_ok    <= 1'b0;
         cmd_err   <= 1'b0;
         ms_cnt    <= '0;
         dwell_cnt <= '0;
         idx       <= '0;
         dir_up    <= 1'b1;
         for (int c = 0; c < N_CH; c++) pos[c] <= '0;
      end else begin
         cmd_ok  <= 1'b0;
         cmd_err <= 1'b0;
         if (us_tick) begin
            ms_cnt <= ms_tick ? 10'd0 : ms_cnt + 10'd1;
         end
         if (modo && ms_tick) begin
            if (dwell_cnt == DWW'(DWELL_MS - 1)) begin
               dwell_cnt <= '0;
               idx       <= idx_next;
               dir_up    <= dir_next;
               for (int c = 0; c < N_CH; c++) pos[c] <= idx_next;
            end else begin
               dwell_cnt <= dwell_cnt + 1'b1;
            end
         end
         if (byte_live) begin
            case (state)
               IDLE: begin
                  if (rx_data == ASC_A) begin
                     modo   <= 1'b0;
                     cmd_ok <= 1'b1;
                  end else if (rx_data == ASC_B) begin
                     modo      <= 1'b1;
                     ms_cnt    <= '0;
                     dwell_cnt <= '0;
                     idx       <= '0;
                     dir_up    <= 1'b1;
                     for (int c = 0; c < N_CH; c++) pos[c] <= '0;
                     cmd_ok    <= 1'b1;
                  end else if (rx_data == ASC_P) begin
                     state <= GOT_P;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
               GOT_P: begin
                  if (is_ch_digit) begin
                     ch    <= CH_W'(rx_data - ASC_0 - 8'd1);
                     state <= GOT_CH;
                  end else begin
                     cmd_err <= 1'b1;
                     state   <= IDLE;
                  end
               end
               GOT_CH: begin
                  state <= IDLE;
                  if (is_pos_digit && !modo) begin
                     pos[ch] <= POS_W'(rx_data - ASC_0 - 8'd1);
                     cmd_ok  <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign pos_flat[c*POS_W +: POS_W] = pos[c];

      servo_pwm_ch #(
         .N_POS  (N_POS),
         .MIN_US (MIN_US),
         .MAX_US (MAX_US),
         .UW     (UW),
         .POS_W  (POS_W)
      ) u_ch (
         .CLK         (CLK),
         .RESET       (RESET),
         .us_cnt      (us_cnt),
         .frame_start (frame_start),
         .pos         (pos[c]),
         .pwm         (pwm[c])
      );
   end

endmodule

// File: tb/tb_bt_servo_multi.sv
// Scoreboarded bench for bt_servo_multi: command responses are queued when a
// byte is driven and matched when cmd_ok/cmd_err fire; pulse widths are counted per frame.
`timescale 1ns/1ps
module tb_bt_servo_multi;

   localparam int CLK_HZ    = 2_000_000;
   localparam int N_CH      = 2;
   localparam int N_POS     = 5;
   localparam int PERIOD_US = 2500;
   localparam int MIN_US    = 1000;
   localparam int MAX_US    = 2000;
   localparam int DWELL_MS  = 2;
   localparam int POS_W     = 3;
   localparam int FRAME_CLK = PERIOD_US * 2;
   localparam int RESP_NONE = 0;
   localparam int RESP_OK   = 1;
   localparam int RESP_ERR  = 2;

   logic                  CLK = 1'b0;
   logic                  RESET = 1'b1;
   logic [7:0]            rx_data = 8'h00;
   logic                  rx_valid = 1'b0;
   logic [N_CH-1:0]       pwm;
   logic                  modo;
   logic [N_CH*POS_W-1:0] pos_flat;
   logic                  frame_start;
   logic                  cmd_ok;
   logic                  cmd_err;

   int checks = 0;
   int failures = 0;
   int exp_q[$];
   int h0, h1;
   int exp_sweep[6] = '{0, 1, 2, 3, 4, 3};

   bt_servo_multi #(
      .CLK_HZ    (CLK_HZ),
      .N_CH      (N_CH),
      .N_POS     (N_POS),
      .PERIOD_US (PERIOD_US),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .DWELL_MS  (DWELL_MS)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .pwm         (pwm),
      .modo        (modo),
      .pos_flat    (pos_flat),
      .frame_start (frame_start),
      .cmd_ok      (cmd_ok),
      .cmd_err     (cmd_err)
   );

   always #5 CLK = ~CLK;

   function automatic int width_clk(input int p);
      return 2 * (MIN_US + p * (MAX_US - MIN_US) / (N_POS - 1));
   endfunction

   function automatic int both_pos(input int p1, input int p2);
      return p1 + (p2 << POS_W);
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int resp);
      if (resp != RESP_NONE) exp_q.push_back(resp);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      repeat (3) @(negedge CLK);
      checkOutput(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_fs();
      int n;
      n = 0;
      while (!frame_start && n < FRAME_CLK + 10) begin
         @(negedge CLK);
         n++;
      end
      if (!frame_start) checkOutput("fs_timeout", 0, 1);
   endtask

   task automatic count_frame(output int c0, output int c1);
      checkOutput("fs_align", int'(frame_start), 1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < FRAME_CLK; i++) begin
         c0 += int'(pwm[0]);
         c1 += int'(pwm[1]);
         @(negedge CLK);
      end
   endtask

   // Response monitor: every cmd_ok/cmd_err pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (!RESET && (cmd_ok || cmd_err)) begin
         checkOutput("resp_excl", int'(cmd_ok & cmd_err), 0);
         if (exp_q.size() == 0)
            checkOutput("resp_unexpected", int'({cmd_err, cmd_ok}), RESP_NONE);
         else
            checkOutput("resp", int'({cmd_err, cmd_ok}), exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge CLK);
      checkOutput("rst_pwm", int'(pwm), 0);
      checkOutput("rst_modo", int'(modo), 0);
      checkOutput("rst_pos", int'(pos_flat), 0);
      checkOutput("rst_flags", int'({cmd_ok, cmd_err, frame_start}), 0);
      RESET = 1'b0;

      $display("[TB] default widths, then P24 mid-pulse");
      wait_fs();
      fork
         count_frame(h0, h1);
         begin
            repeat (200) @(negedge CLK);
            applyStimulus("P", RESP_NONE);
            applyStimulus("2", RESP_NONE);
            applyStimulus("4", RESP_OK);
         end
      join
      checkOutput("f0_ch1", h0, width_clk(0));
      checkOutput("f0_ch2", h1, width_clk(0));
      checkOutput("p24_pos", int'(pos_flat), both_pos(0, 3));
      count_frame(h0, h1);
      checkOutput("f1_ch1", h0, width_clk(0));
      checkOutput("f1_ch2", h1, width_clk(3));

      $display("[TB] error paths");
      applyStimulus("X", RESP_ERR);
      applyStimulus("P", RESP_NONE);
      applyStimulus("7", RESP_ERR);
      applyStimulus("P", RESP_NONE);
      applyStimulus("1", RESP_NONE);
      applyStimulus("9", RESP_ERR);
      applyStimulus("P", RESP_NONE);
      applyStimulus(8'h0D, RESP_NONE);
      applyStimulus("1", RESP_NONE);
      applyStimulus(8'h0A, RESP_NONE);
      applyStimulus("2", RESP_OK);
      drain("err_drain");
      checkOutput("err_pos", int'(pos_flat), both_pos(1, 3));

      $display("[TB] byte on frame_start cycle");
      wait_fs();
      fork
         begin
            repeat (FRAME_CLK) @(negedge CLK);
            count_frame(h0, h1);
            checkOutput("fsb_old_ch1", h0, width_clk(1));
            checkOutput("fsb_old_ch2", h1, width_clk(3));
            count_frame(h0, h1);
            checkOutput("fsb_new_ch1", h0, width_clk(4));
            checkOutput("fsb_new_ch2", h1, width_clk(3));
         end
         begin
            repeat (FRAME_CLK - 2) @(negedge CLK);
            applyStimulus("P", RESP_NONE);
            applyStimulus("1", RESP_NONE);
            applyStimulus("5", RESP_OK);
         end
      join
      checkOutput("fsb_pos", int'(pos_flat), both_pos(4, 3));

      $display("[TB] mode B sweep");
      applyStimulus("B", RESP_OK);
      checkOutput("b_modo", int'(modo), 1);
      repeat (2000) @(negedge CLK);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("sweep_%0d", k), int'(pos_flat),
                     both_pos(exp_sweep[k], exp_sweep[k]));
         if (k < 5) repeat (4000) @(negedge CLK);
      end
      applyStimulus("P", RESP_NONE);
      applyStimulus("1", RESP_NONE);
      applyStimulus("3", RESP_ERR);
      drain("b_drain");
      checkOutput("b_pos_kept", int'(pos_flat), both_pos(3, 3));
      applyStimulus("A", RESP_OK);
      drain("a_drain");
      checkOutput("a_modo", int'(modo), 0);
      checkOutput("a_pos_kept", int'(pos_flat), both_pos(3, 3));

      $display("[TB] reset mid-pulse and mid-command");
      wait_fs();
      repeat (100) @(negedge CLK);
      checkOutput("pre_rst_pwm", int'(pwm), 3);
      applyStimulus("P", RESP_NONE);
      applyStimulus("1", RESP_NONE);
      RESET = 1'b1;
      @(negedge CLK);
      checkOutput("mid_rst_pwm", int'(pwm), 0);
      checkOutput("mid_rst_pos", int'(pos_flat), 0);
      checkOutput("mid_rst_modo", int'(modo), 0);
      RESET = 1'b0;
      applyStimulus("3", RESP_ERR);
      drain("rst_drain");
      checkOutput("rst_pos_after", int'(pos_flat), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
